ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//   Receives PS/2 keyboard frames (device-to-host) and recovers 8-bit scan codes.
//   Keeps the two most recent bytes as four hex nibbles for the downstream hex_7seg
//   digit decoders, one decoder per nibble.
//   Sits between the board PS/2 pins and the display/key-handling logic.
// PARAMETERS
//   TIMEOUT_CYCLES  50000  clk cycles (1 ms @ 50 MHz) with no ps2_clk fall before an in-progress frame is aborted
//   SYNC_STAGES     2      flip-flop stages in the ps2_clk/ps2_data synchronisers (>=2)
// PORTS
//   clk         in   1   system clock; 50 MHz nominal
//   reset       in   1   synchronous, active-high
//   ps2_clk     in   1   PS/2 clock pin; async, idles high
//   ps2_data    in   1   PS/2 data pin; async, idles high
//   scan_code   out  8   last good byte; held until the next good byte
//   code_valid  out  1   1-cycle pulse; scan_code updated this cycle
//   parity_err  out  1   1-cycle pulse; frame discarded on odd-parity failure
//   frame_err   out  1   1-cycle pulse; bad stop bit or timeout, frame discarded
//   disp_word   out  16  {previous byte, latest byte}; [15:12]..[3:0] drive hex digits 3..0
//   busy        out  1   high while FSM is not in IDLE
// BEHAVIOUR
//   Reset (sync, active-high)
//   - state=IDLE; scan_code, disp_word, bit_cnt, shift reg and timeout count = 0.
//   - All pulses = 0. Synchroniser flops preset to 1 (idle level).
//   - Reset has priority over everything; a partial frame is dropped with no error pulse.
//   Sampling
//   - Both pins pass through SYNC_STAGES flops.
//   - fall = sync_clk_d1 & ~sync_clk; data is sampled only on a cycle with fall=1.
//   FSM, one transition per fall:
//   - IDLE: data=0 (start bit) -> DATA with bit_cnt=0. data=1 -> stay in IDLE, no error (glitch).
//   - DATA: shift data into bit[bit_cnt], LSB first. bit_cnt 7 -> PARITY, else bit_cnt+1.
//   - PARITY: latch the parity bit -> STOP.
//   - STOP, evaluated in the same cycle as the fall:
//     - stop=1 and ^{byte,parity}=1 (odd): code_valid=1 next cycle; scan_code<=byte;
//       disp_word<={disp_word[7:0],byte}.
//     - stop=1 and parity even: parity_err=1 next cycle; scan_code/disp_word unchanged.
//     - stop=0: frame_err=1 next cycle (overrides parity result); no update.
//     - All STOP cases -> IDLE.
//   Latency
//   - Stop-bit fall on the pin -> code_valid is SYNC_STAGES+2 clk cycles (4 at defaults).
//   - Outputs are registered.
//   Timeout
//   - Counter clears on every fall and in IDLE; increments otherwise.
//   - If it reaches TIMEOUT_CYCLES-1 while not IDLE: frame_err pulse, -> IDLE, counter clears.
//   - Timeout and fall in the same cycle: the fall wins and the counter clears.
//   Pulse rules
//   - At most one of code_valid/parity_err/frame_err per frame, never simultaneous.
//   - Pulses never stretch past 1 cycle.
//   - Back-to-back frames (start bit arriving the fall after stop) are accepted without loss.
//   - Host-to-device transmission is out of scope; ps2_clk/ps2_data are input-only here.
// STRUCTURE
//   - Shared include ps2_defs.vh:
//     - FSM state localparams: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
//     - PS2_FRAME_BITS=11, PS2_DATA_BITS=8.
//     - Scan-code constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0.
//   - One sub-module, ps2_sync_edge: SYNC_STAGES synchroniser for both pins plus the
//     ps2_clk fall detector. Outputs sync_data and fall.
//   - FSM, shift register, timeout counter and display register live in the top.
// TESTING
//   Bus model: ps2_clk period 60 us, data changes mid-high; clk 50 MHz.
//   1. Reset, then frame 0x1C (parity 0, stop 1)
//      -> code_valid 1 cycle; scan_code=8'h1C; disp_word=16'h001C.
//   2. Frames 0xF0 (parity 1) then 0x1C, back-to-back
//      -> two code_valid pulses; disp_word 16'h1CF0 then 16'hF01C.
//   3. Frame 0x1C with parity 1
//      -> parity_err 1 cycle; no code_valid; scan_code/disp_word unchanged.
//   4. Frame 0x5A with stop bit 0
//      -> frame_err 1 cycle; busy=0 afterwards; next good frame 0x5A accepted normally.
//   5. Start bit + 4 data bits, then ps2_clk held high 50000 cycles
//      -> frame_err exactly at the timeout count; next frame 0x29 accepted.
//   6. Assert reset after bit 5 of a frame; single 1-cycle ps2_clk low with data=1 in IDLE
//      -> no pulses, state IDLE, outputs 0; a following frame 0x1C decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_rx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scancode_rx_pkg
//   Shared definitions for the PS/2 scan-code receiver: FSM state encoding,
//   frame geometry, well-known scan-code prefixes and a parity helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package ps2_scancode_rx_pkg;

  // Receiver FSM states; encoding fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;  // start + 8 data + parity + stop
  localparam int PS2_DATA_BITS  = 8;

  // Prefix bytes used by downstream key handling (break / extended codes).
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of 1s.
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
//   Brings the asynchronous PS/2 clock and data pins into the clk domain and
//   produces a registered one-cycle strobe on each ps2_clk falling edge.
//   Ports:
//     clk, reset      system clock, synchronous active-high reset
//     ps2_clk         PS/2 clock pin (async, idles high)
//     ps2_data        PS/2 data pin  (async, idles high)
//     sync_data       synchronised data, aligned with fall
//     fall            1-cycle strobe: synchronised ps2_clk went 1 -> 0
// ---------------------------------------------------------------------------
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sync_data,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   sync_clk_d1_reg;
  logic                   fall_reg;
  logic                   sync_data_reg;

  // Synchroniser chains preset to the bus idle level so reset never looks
  // like a falling edge.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            clk_sync_reg[gi]  <= 1'b1;
            data_sync_reg[gi] <= 1'b1;
          end else begin
            clk_sync_reg[gi]  <= ps2_clk;
            data_sync_reg[gi] <= ps2_data;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) begin
            clk_sync_reg[gi]  <= 1'b1;
            data_sync_reg[gi] <= 1'b1;
          end else begin
            clk_sync_reg[gi]  <= clk_sync_reg[gi-1];
            data_sync_reg[gi] <= data_sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Edge detect is registered together with the data so the FSM sees the
  // data bit that was on the pin at the moment of the fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_clk_d1_reg <= 1'b1;
      fall_reg        <= 1'b0;
      sync_data_reg   <= 1'b1;
    end else begin
      sync_clk_d1_reg <= clk_sync_reg[SYNC_STAGES-1];
      fall_reg        <= sync_clk_d1_reg & ~clk_sync_reg[SYNC_STAGES-1];
      sync_data_reg   <= data_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_data = sync_data_reg;
  assign fall      = fall_reg;

endmodule

// File: rtl/ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// ps2_scancode_rx
//   PS/2 device-to-host frame receiver. Recovers 8-bit scan codes, checks odd
//   parity and the stop bit, aborts stalled frames after TIMEOUT_CYCLES, and
//   keeps the two most recent good bytes for four hex digit decoders.
//   Ports:
//     clk, reset   system clock (50 MHz nominal), synchronous active-high reset
//     ps2_clk      PS/2 clock pin, async
//     ps2_data     PS/2 data pin, async
//     scan_code    last good byte, held until the next good byte
//     code_valid   1-cycle pulse when scan_code updates
//     parity_err   1-cycle pulse, frame dropped on parity failure
//     frame_err    1-cycle pulse, frame dropped on bad stop bit or timeout
//     disp_word    {previous byte, latest byte}
//     busy         high while a frame is in progress
// ---------------------------------------------------------------------------
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  scan_code,
  output logic        code_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic [15:0] disp_word,
  output logic        busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic sync_data;
  logic fall;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .sync_data(sync_data),
    .fall     (fall)
  );

  ps2_state_e               state_reg,      state_next;
  logic [2:0]               bit_cnt_reg,    bit_cnt_next;
  logic [PS2_DATA_BITS-1:0] shift_reg,      shift_next;
  logic                     parity_reg,     parity_next;
  logic [TO_W-1:0]          timeout_reg,    timeout_next;
  logic [7:0]               scan_code_reg,  scan_code_next;
  logic [15:0]              disp_word_reg,  disp_word_next;
  logic                     code_valid_reg, code_valid_next;
  logic                     parity_err_reg, parity_err_next;
  logic                     frame_err_reg,  frame_err_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      timeout_reg    <= '0;
      scan_code_reg  <= '0;
      disp_word_reg  <= '0;
      code_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_reg     <= parity_next;
      timeout_reg    <= timeout_next;
      scan_code_reg  <= scan_code_next;
      disp_word_reg  <= disp_word_next;
      code_valid_reg <= code_valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_next     = parity_reg;
    scan_code_next  = scan_code_reg;
    disp_word_next  = disp_word_reg;
    code_valid_next = 1'b0;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;

    // Watchdog only runs between falls of an in-progress frame.
    if (state_reg == IDLE || fall) begin
      timeout_next = '0;
    end else begin
      timeout_next = timeout_reg + TO_W'(1);
    end

    if (fall) begin
      // A fall always wins over a timeout landing in the same cycle.
      case (state_reg)
        IDLE: begin
          // A high sample here is a glitch, not a start bit; ignore quietly.
          if (!sync_data) begin
            state_next   = DATA;
            bit_cnt_next = '0;
            shift_next   = '0;
          end
        end
        DATA: begin
          shift_next[bit_cnt_reg] = sync_data;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
        PARITY: begin
          parity_next = sync_data;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          // A bad stop bit makes the parity result meaningless.
          if (!sync_data) begin
            frame_err_next = 1'b1;
          end else if (ps2_parity_ok(shift_reg, parity_reg)) begin
            code_valid_next = 1'b1;
            scan_code_next  = shift_reg;
            disp_word_next  = {disp_word_reg[7:0], shift_reg};
          end else begin
            parity_err_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && timeout_reg == TO_LAST) begin
      frame_err_next = 1'b1;
      state_next     = IDLE;
      timeout_next   = '0;
    end
  end

  assign scan_code  = scan_code_reg;
  assign code_valid = code_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign disp_word  = disp_word_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_rx
//   Directed bench for ps2_scancode_rx. Uses a shortened timeout and a fast
//   PS/2 bus so the whole run stays short; latencies are checked in clk
//   cycles relative to the ps2_clk fall the bench drove.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_rx;

  localparam int TIMEOUT = 400;
  localparam int SYNC    = 2;
  localparam int H       = 20;  // ps2_clk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [7:0]  scan_code;
  logic        code_valid;
  logic        parity_err;
  logic        frame_err;
  logic [15:0] disp_word;
  logic        busy;

  ps2_scancode_rx #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .disp_word (disp_word),
    .busy      (busy)
  );

  always #10 clk = ~clk;  // 50 MHz

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling clk edge.
  int          cv_n = 0, pe_n = 0, fe_n = 0;
  int          cv_cyc = 0, fe_cyc = 0;
  int          stretch_n = 0, multi_n = 0;
  logic [15:0] cv_disp_log [32];
  logic        cv_prev = 1'b0, pe_prev = 1'b0, fe_prev = 1'b0;

  always @(negedge clk) begin
    if (code_valid) begin
      if (cv_n < 32) cv_disp_log[cv_n] = disp_word;
      cv_n   = cv_n + 1;
      cv_cyc = cyc;
    end
    if (parity_err) pe_n = pe_n + 1;
    if (frame_err) begin
      fe_n   = fe_n + 1;
      fe_cyc = cyc;
    end
    if ((code_valid && cv_prev) || (parity_err && pe_prev) || (frame_err && fe_prev))
      stretch_n = stretch_n + 1;
    if ((int'(code_valid) + int'(parity_err) + int'(frame_err)) > 1)
      multi_n = multi_n + 1;
    cv_prev = code_valid;
    pe_prev = parity_err;
    fe_prev = frame_err;
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_fall_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      $display("check %-22s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus bit: data set mid-high, then a full low phase, then high.
  task automatic ps2_bit(input logic v);
    ps2_data = v;
    idle(H / 2);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    idle(H);
    ps2_clk = 1'b1;
    idle(H / 2);
  endtask

  // nbits < 8 sends only start + nbits data bits and leaves the bus stalled.
  task automatic ps2_frame(input logic [7:0] b, input logic par, input logic stp,
                           input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    if (nbits == 8) begin
      ps2_bit(par);
      ps2_bit(stp);
    end
    ps2_data = 1'b1;
  endtask

  int cv0, pe0, fe0;

  task automatic snap;
    cv0 = cv_n;
    pe0 = pe_n;
    fe0 = fe_n;
  endtask

  initial begin
    // Reset state
    idle(5);
    chk("rst_scan_code", 32'(scan_code), 32'h00);
    chk("rst_disp_word", 32'(disp_word), 32'h0000);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pulses", 32'({code_valid, parity_err, frame_err}), 32'h0);
    reset = 1'b0;
    idle(5);

    // 1: single good frame 0x1C (three ones -> parity 0)
    snap();
    ps2_frame(8'h1C, 1'b0, 1'b1, 8);
    idle(5);
    chk("t1_code_valid_cnt", 32'(cv_n - cv0), 32'd1);
    chk("t1_err_cnt", 32'((pe_n - pe0) + (fe_n - fe0)), 32'd0);
    chk("t1_latency", 32'(cv_cyc - last_fall_cyc), 32'(SYNC + 2));
    chk("t1_scan_code", 32'(scan_code), 32'h1C);
    chk("t1_disp_word", 32'(disp_word), 32'h001C);
    chk("t1_busy", 32'(busy), 32'h0);

    // 2: back-to-back 0xF0 (parity 1) then 0x1C
    snap();
    ps2_frame(8'hF0, 1'b1, 1'b1, 8);
    ps2_frame(8'h1C, 1'b0, 1'b1, 8);
    idle(5);
    chk("t2_code_valid_cnt", 32'(cv_n - cv0), 32'd2);
    chk("t2_disp_first", 32'(cv_disp_log[cv0]), 32'h1CF0);
    chk("t2_disp_second", 32'(cv_disp_log[cv0+1]), 32'hF01C);
    chk("t2_scan_code", 32'(scan_code), 32'h1C);

    // 3: 0x1C with wrong parity
    snap();
    ps2_frame(8'h1C, 1'b1, 1'b1, 8);
    idle(5);
    chk("t3_parity_err_cnt", 32'(pe_n - pe0), 32'd1);
    chk("t3_code_valid_cnt", 32'(cv_n - cv0), 32'd0);
    chk("t3_frame_err_cnt", 32'(fe_n - fe0), 32'd0);
    chk("t3_scan_code", 32'(scan_code), 32'h1C);
    chk("t3_disp_word", 32'(disp_word), 32'hF01C);

    // 4: 0x5A with bad stop bit, then a good 0x5A
    snap();
    ps2_frame(8'h5A, 1'b1, 1'b0, 8);
    idle(5);
    chk("t4_frame_err_cnt", 32'(fe_n - fe0), 32'd1);
    chk("t4_other_cnt", 32'((cv_n - cv0) + (pe_n - pe0)), 32'd0);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_disp_hold", 32'(disp_word), 32'hF01C);
    snap();
    ps2_frame(8'h5A, 1'b1, 1'b1, 8);
    idle(5);
    chk("t4_good_cnt", 32'(cv_n - cv0), 32'd1);
    chk("t4_disp_word", 32'(disp_word), 32'h1C5A);

    // 5: stalled frame -> timeout, then 0x29
    snap();
    ps2_frame(8'h00, 1'b0, 1'b1, 4);
    idle(H);
    chk("t5_busy_stalled", 32'(busy), 32'h1);
    idle(TIMEOUT + 40);
    chk("t5_frame_err_cnt", 32'(fe_n - fe0), 32'd1);
    chk("t5_timeout_cycle", 32'(fe_cyc - last_fall_cyc), 32'(TIMEOUT + SYNC + 2));
    chk("t5_other_cnt", 32'((cv_n - cv0) + (pe_n - pe0)), 32'd0);
    chk("t5_busy", 32'(busy), 32'h0);
    snap();
    ps2_frame(8'h29, 1'b0, 1'b1, 8);
    idle(5);
    chk("t5_good_cnt", 32'(cv_n - cv0), 32'd1);
    chk("t5_scan_code", 32'(scan_code), 32'h29);
    chk("t5_disp_word", 32'(disp_word), 32'h5A29);

    // 6: reset mid-frame, glitch in IDLE, then 0x1C
    snap();
    ps2_frame(8'h1C, 1'b0, 1'b1, 5);
    idle(3);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(10);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_scan_code", 32'(scan_code), 32'h00);
    chk("t6_disp_word", 32'(disp_word), 32'h0000);
    ps2_data = 1'b1;
    ps2_clk = 1'b0;
    idle(1);
    ps2_clk = 1'b1;
    idle(10);
    chk("t6_glitch_busy", 32'(busy), 32'h0);
    chk("t6_no_pulses", 32'((cv_n - cv0) + (pe_n - pe0) + (fe_n - fe0)), 32'd0);
    ps2_frame(8'h1C, 1'b0, 1'b1, 8);
    idle(5);
    chk("t6_good_cnt", 32'(cv_n - cv0), 32'd1);
    chk("t6_scan_code", 32'(scan_code), 32'h1C);
    chk("t6_disp_word", 32'(disp_word), 32'h001C);

    // Whole-run pulse rules
    chk("pulse_stretch", 32'(stretch_n), 32'd0);
    chk("pulse_overlap", 32'(multi_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
